// File: rtl/io_page_pkg.sv
// Shared definitions for the I/O page responder: register word offsets,
// access FSM encoding, timer reset constants and a byte-lane merge helper.
package io_page_pkg;

  // Word offsets, i.e. addr[7:1]; byte address 0xFFnn maps to nn >> 1.
  localparam logic [6:0] OFS_LED     = 7'h00;
  localparam logic [6:0] OFS_HEX     = 7'h01;
  localparam logic [6:0] OFS_INPUT   = 7'h02;
  localparam logic [6:0] OFS_COUNT   = 7'h03;
  localparam logic [6:0] OFS_COMPARE = 7'h04;
  localparam logic [6:0] OFS_STATUS  = 7'h05;
  localparam logic [6:0] OFS_PRELOAD = 7'h06;

  localparam logic [15:0] COMPARE_RST = 16'hFFFF;
  localparam logic [15:0] PRELOAD_RST = 16'h0000;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } state_e;

  function automatic logic [15:0] byte_merge(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic [1:0]  be);
    byte_merge = {be[1] ? new_v[15:8] : old_v[15:8],
                  be[0] ? new_v[7:0]  : old_v[7:0]};
  endfunction

endpackage

// File: rtl/io_timer.sv
// Prescaled 16-bit up-counter with compare match and sticky interrupt.
module io_timer
  import io_page_pkg::*;
#(
  parameter int unsigned PRE_W = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [1:0]  cmp_we_i,
  input  logic [1:0]  pre_we_i,
  input  logic [15:0] wdata_i,
  input  logic        irq_clr_i,
  output logic [15:0] count_o,
  output logic [15:0] compare_o,
  output logic [15:0] preload_o,
  output logic        irq_o
);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] preload_q, preload_d;
  logic [15:0]      count_q, count_d;
  logic [15:0]      compare_q, compare_d;
  logic             irq_q, irq_d;
  logic             tick;

  always_comb begin
    tick      = (pre_q == '0);
    pre_d     = tick ? preload_q : pre_q - PRE_W'(1);
    count_d   = tick ? count_q + 16'd1 : count_q;
    // Only a fresh arrival at COMPARE sets irq; a set beats a same-cycle clear.
    irq_d     = (tick && (count_d == compare_q)) || (irq_q && !irq_clr_i);
    compare_d = byte_merge(compare_q, wdata_i, cmp_we_i);
    preload_d = PRE_W'(byte_merge(16'(preload_q), wdata_i, pre_we_i));
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pre_q     <= '0;
      preload_q <= PRE_W'(PRELOAD_RST);
      count_q   <= '0;
      compare_q <= COMPARE_RST;
      irq_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      preload_q <= preload_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      irq_q     <= irq_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign preload_o = 16'(preload_q);
  assign irq_o     = irq_q;

endmodule

// File: rtl/io_page_responder.sv
// b16 bus responder for one address page: LED/HEX registers, synchronized
// switch/key inputs and a compare timer, each access taking one wait state.
module io_page_responder
  import io_page_pkg::*;
#(
  parameter logic [7:0]  BASE        = 8'hFF,
  parameter int unsigned PRE_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] addr,
  input  logic        r,
  input  logic [1:0]  w,
  input  logic [15:0] dwrite,
  output logic [15:0] rdata,
  output logic        ready,
  input  logic [9:0]  sw_in,
  input  logic [3:0]  key_in,
  output logic [15:0] led_out,
  output logic [15:0] hex_out,
  output logic        irq
);

  state_e state_q, state_d;
  logic [15:0] led_q, led_d, hex_q, hex_d, rdata_q, rdata_d, rd_mux;
  logic [SYNC_STAGES-1:0][9:0] sw_sync_q;
  logic [SYNC_STAGES-1:0][3:0] key_sync_q;
  logic [9:0]  sw_sync;
  logic [3:0]  key_sync;
  logic [6:0]  ofs;
  logic        hit, acc;
  logic [1:0]  be, cmp_we, pre_we;
  logic        irq_clr;
  logic [15:0] count_w, compare_w, preload_w;
  logic        unused_addr0;

  assign unused_addr0 = addr[0];
  assign ofs      = addr[7:1];
  assign hit      = (addr[15:8] == BASE) && (r || (|w));
  assign acc      = (state_q == ST_IDLE) && hit;
  assign sw_sync  = sw_sync_q[SYNC_STAGES-1];
  assign key_sync = key_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sw_sync_q  <= '0;
      key_sync_q <= '0;
    end else begin
      sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], sw_in};
      key_sync_q <= {key_sync_q[SYNC_STAGES-2:0], key_in};
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = !(acc && nreset);
  end

  // Writes and the read sample both happen on the IDLE->ACK edge; a read wins over a write.
  always_comb begin
    be      = (acc && !r) ? w : 2'b00;
    led_d   = (ofs == OFS_LED) ? byte_merge(led_q, dwrite, be) : led_q;
    hex_d   = (ofs == OFS_HEX) ? byte_merge(hex_q, dwrite, be) : hex_q;
    cmp_we  = (ofs == OFS_COMPARE) ? be : 2'b00;
    pre_we  = (ofs == OFS_PRELOAD) ? be : 2'b00;
    irq_clr = (ofs == OFS_STATUS) && be[0] && dwrite[0];
    case (ofs)
      OFS_LED:     rd_mux = led_q;
      OFS_HEX:     rd_mux = hex_q;
      OFS_INPUT:   rd_mux = {~key_sync, 2'b00, sw_sync};
      OFS_COUNT:   rd_mux = count_w;
      OFS_COMPARE: rd_mux = compare_w;
      OFS_STATUS:  rd_mux = {15'b0, irq};
      OFS_PRELOAD: rd_mux = preload_w;
      default:     rd_mux = '0;
    endcase
    rdata_d = (acc && r) ? rd_mux : '0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      led_q   <= '0;
      hex_q   <= '0;
      rdata_q <= '0;
    end else begin
      led_q   <= led_d;
      hex_q   <= hex_d;
      rdata_q <= rdata_d;
    end
  end

  io_timer #(.PRE_W(PRE_W)) u_timer (
    .clk       (clk),
    .nreset    (nreset),
    .cmp_we_i  (cmp_we),
    .pre_we_i  (pre_we),
    .wdata_i   (dwrite),
    .irq_clr_i (irq_clr),
    .count_o   (count_w),
    .compare_o (compare_w),
    .preload_o (preload_w),
    .irq_o     (irq)
  );

  assign rdata   = rdata_q;
  assign led_out = led_q;
  assign hex_out = hex_q;

endmodule

// File: tb/tb_io_page_responder.sv
// Scoreboard bench for io_page_responder: a register-map reference model
// predicts read data and outputs; a negedge monitor compares against the DUT.
module tb_io_page_responder;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [15:0] addr = '0;
  logic        r = 1'b0;
  logic [1:0]  w = '0;
  logic [15:0] dwrite = '0;
  logic [9:0]  sw_in = '0;
  logic [3:0]  key_in = 4'hF;
  logic [15:0] rdata, led_out, hex_out;
  logic        ready, irq;

  int total = 0;
  int bad   = 0;

  io_page_responder #(.BASE(8'hFF), .PRE_W(16), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .nreset(nreset), .addr(addr), .r(r), .w(w), .dwrite(dwrite),
    .rdata(rdata), .ready(ready), .sw_in(sw_in), .key_in(key_in),
    .led_out(led_out), .hex_out(hex_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_led = '0, m_hex = '0, m_cmp = 16'hFFFF, m_cnt = '0, m_preload = '0;
  int          m_ticks_left = 0;
  logic        m_irq = 1'b0, m_busy = 1'b0;
  logic [9:0]  sw_hist[$];
  logic [3:0]  key_hist[$];
  logic [9:0]  m_sw_s;
  logic [3:0]  m_key_s;
  logic [15:0] expq[$];

  function automatic logic [15:0] lanes(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
    logic [15:0] v;
    v = o;
    if (be[0]) v[7:0]  = n[7:0];
    if (be[1]) v[15:8] = n[15:8];
    return v;
  endfunction

  function automatic logic [15:0] model_read(input logic [7:0] byte_ofs);
    case (byte_ofs)
      8'h00:   return m_led;
      8'h02:   return m_hex;
      8'h04:   return {~m_key_s, 2'b00, m_sw_s};
      8'h06:   return m_cnt;
      8'h08:   return m_cmp;
      8'h0A:   return {15'b0, m_irq};
      8'h0C:   return m_preload;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic bus_hit();
    return (addr[15:8] == 8'hFF) && (r || (w != 2'b00));
  endfunction

  logic [15:0] old_cmp, old_pre;
  logic        m_clr, m_set;
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_led = '0; m_hex = '0; m_cmp = 16'hFFFF; m_cnt = '0; m_preload = '0;
      m_ticks_left = 0; m_irq = 1'b0; m_busy = 1'b0;
      sw_hist.delete(); key_hist.delete(); expq.delete();
      for (int i = 0; i < SYNC; i++) begin
        sw_hist.push_front(10'h0);
        key_hist.push_front(4'h0);
      end
    end else begin
      m_sw_s  = sw_hist[$];
      m_key_s = key_hist[$];
      sw_hist.push_front(sw_in);   void'(sw_hist.pop_back());
      key_hist.push_front(key_in); void'(key_hist.pop_back());
      old_cmp = m_cmp;
      old_pre = m_preload;
      m_clr = 1'b0;
      m_set = 1'b0;
      if (!m_busy && bus_hit()) begin
        expq.push_back(r ? model_read({addr[7:1], 1'b0}) : 16'h0000);
        if (!r) begin
          case ({addr[7:1], 1'b0})
            8'h00: m_led     = lanes(m_led, dwrite, w);
            8'h02: m_hex     = lanes(m_hex, dwrite, w);
            8'h08: m_cmp     = lanes(m_cmp, dwrite, w);
            8'h0A: m_clr     = w[0] && dwrite[0];
            8'h0C: m_preload = lanes(m_preload, dwrite, w);
            default: ;
          endcase
        end
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
      // COUNT advances once every (PRELOAD+1) clocks
      if (m_ticks_left == 0) begin
        m_ticks_left = int'(old_pre);
        m_cnt = m_cnt + 16'd1;
        m_set = (m_cnt == old_cmp);
      end else begin
        m_ticks_left--;
      end
      m_irq = m_set || (m_irq && !m_clr);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (nreset) begin
      if (m_busy) begin
        chk("ready_ack", ready, 1);
        if (expq.size() == 0) chk("sb_empty", 0, 1);
        else chk("rdata", rdata, expq.pop_front());
      end else begin
        chk("ready_idle", ready, !bus_hit());
        chk("rdata_idle", rdata, 0);
      end
      chk("led", led_out, m_led);
      chk("hex", hex_out, m_hex);
      chk("irq", irq, m_irq);
    end
  end

  // ---------------- driver ----------------
  task automatic bus(input logic [15:0] a, input logic rr, input logic [1:0] ww,
                     input logic [15:0] d, output logic [15:0] rd);
    int nwait;
    logic got, exp_hit;
    @(posedge clk); #1;
    addr = a; r = rr; w = ww; dwrite = d;
    exp_hit = bus_hit();
    got = 1'b0; nwait = 0; rd = 'x;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready) begin got = 1'b1; rd = rdata; break; end
      nwait++;
    end
    chk("ready_timeout", got, 1);
    chk("wait_states", nwait, exp_hit ? 1 : 0);
    #1;
    r = 1'b0; w = 2'b00;
  endtask

  logic [15:0] rd, c;
  initial begin
    #12 nreset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_led", led_out, 0);
    chk("rst_irq", irq, 0);
    bus(16'hFF08, 1, 2'b00, 16'h0, rd); chk("cmp_rst_read", rd, 16'hFFFF);

    bus(16'hFF00, 0, 2'b11, 16'hA55A, rd);
    bus(16'hFF00, 0, 2'b01, 16'h00FF, rd);
    chk("led_bytes", led_out, 16'hA5FF);

    @(posedge clk); #1 sw_in = 10'h2AA; key_in = 4'b1110;
    repeat (3) @(posedge clk);
    bus(16'hFF04, 1, 2'b00, 16'h0, rd); chk("input_read", rd, 16'h12AA);

    bus(16'hFF0C, 0, 2'b11, 16'h0003, rd);
    c = m_cnt + 16'd5;
    bus(16'hFF08, 0, 2'b11, c, rd);
    for (int i = 0; i < 60 && !irq; i++) @(negedge clk);
    chk("irq_rise", irq, 1);
    bus(16'hFF0A, 0, 2'b01, 16'h0001, rd);
    chk("irq_clear", irq, 0);

    bus(16'hFF0C, 0, 2'b11, 16'h0000, rd);
    for (int d = 1; d <= 6; d++) begin
      c = m_cnt + 16'(d);
      bus(16'hFF08, 0, 2'b11, c, rd);
      bus(16'hFF0A, 0, 2'b01, 16'h0001, rd);
      if (d == 4) chk("set_wins", irq, 1);
    end

    bus(16'hFF1E, 1, 2'b00, 16'h0, rd); chk("unmapped_read", rd, 0);
    bus(16'hFF20, 0, 2'b11, 16'hBEEF, rd);
    bus(16'hFE00, 1, 2'b00, 16'h0, rd); chk("other_page_rd", rd, 0);
    bus(16'hFF02, 1, 2'b11, 16'h1234, rd); chk("rw_read_wins", rd, m_hex);

    // reset in the middle of a pending LED write
    @(posedge clk); #1;
    addr = 16'hFF00; r = 1'b0; w = 2'b11; dwrite = 16'h1234;
    #1 nreset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", ready, 1);
    chk("midrst_led", led_out, 0);
    #1 w = 2'b00;
    #1 nreset = 1'b1;
    @(negedge clk);
    chk("postrst_led", led_out, 0);

    for (int n = 0; n < 250; n++) begin
      logic [6:0]  wo;
      logic [15:0] a;
      logic        rr;
      logic [1:0]  ww;
      case ($urandom_range(0, 9))
        0: wo = 7'h0F;
        1: wo = 7'h10;
        2: wo = 7'h7F;
        default: wo = 7'($urandom_range(0, 6));
      endcase
      a = {8'hFF, wo, 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 9) == 0) a[15:8] = 8'($urandom_range(0, 254));
      rr = 1'($urandom_range(0, 1));
      ww = 2'($urandom_range(0, 3));
      if (!rr && ww == 2'b00) rr = 1'b1;
      if (wo == 7'h06 && !rr) ww = 2'b00;
      if (ww == 2'b00) rr = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        sw_in  = 10'($urandom);
        key_in = 4'($urandom);
      end
      bus(a, rr, ww, 16'($urandom), rd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
